// File: rtl/id_group_splitter.sv
// Decode-group splitter: issues the longest legal in-order prefix of the queue-head
// packet each cycle, tracking issued slots so large or hazardous packets drain over several cycles.
module id_group_splitter #(
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned MAX_BR   = 1,
    parameter int unsigned MAX_MEM  = 1,
    parameter int unsigned ARF_IDX  = 5,
    parameter int unsigned CNT_W    = $clog2(ID_WIDTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ID_WIDTH-1:0]                in_slot_valid,
    input  logic [ID_WIDTH-1:0][31:0]          in_inst,
    input  logic [ID_WIDTH-1:0][1:0]           in_rs_type,
    input  logic [ID_WIDTH-1:0][ARF_IDX-1:0]   in_rd_arch,
    input  logic [CNT_W-1:0]                   fl_avail,
    input  logic [CNT_W-1:0]                   rob_avail,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ID_WIDTH-1:0]                out_mask,
    output logic [ID_WIDTH-1:0]                out_rd_need,
    output logic                               out_last
);

    localparam logic [1:0] RS_MEM = 2'd1;
    localparam logic [1:0] RS_BR  = 2'd2;

    logic [ID_WIDTH-1:0] done;
    logic [ID_WIDTH-1:0] live;
    logic [ID_WIDTH-1:0] is_br;
    logic [ID_WIDTH-1:0] is_mem;
    logic [ID_WIDTH-1:0] rd_need;
    logic [ID_WIDTH-1:0] sel;
    logic                any_live;
    logic                fire;

    // Per-slot attributes; all-zero instructions count as dead slots
    always_comb begin
        live    = '0;
        is_br   = '0;
        is_mem  = '0;
        rd_need = '0;
        for (int i = 0; i < int'(ID_WIDTH); i++) begin
            live[i]    = in_slot_valid[i] & (in_inst[i] != 32'h0) & ~done[i];
            is_br[i]   = (in_rs_type[i] == RS_BR);
            is_mem[i]  = (in_rs_type[i] == RS_MEM);
            rd_need[i] = (in_rd_arch[i] != '0);
        end
    end

    // In-order prefix scan: first failing live slot or a taken branch ends the group
    always_comb begin
        int unsigned n_br;
        int unsigned n_mem;
        int unsigned n_rd;
        int unsigned n_tot;
        logic        stop;
        logic        ok;
        sel   = '0;
        n_br  = 0;
        n_mem = 0;
        n_rd  = 0;
        n_tot = 0;
        stop  = 1'b0;
        ok    = 1'b0;
        for (int i = 0; i < int'(ID_WIDTH); i++) begin
            if (!stop && live[i]) begin
                ok = ((n_br  + 32'(is_br[i]))   <= MAX_BR)
                   & ((n_mem + 32'(is_mem[i]))  <= MAX_MEM)
                   & ((n_rd  + 32'(rd_need[i])) <= 32'(fl_avail))
                   & ((n_tot + 32'd1)           <= 32'(rob_avail));
                if (ok) begin
                    sel[i] = 1'b1;
                    n_br   = n_br  + 32'(is_br[i]);
                    n_mem  = n_mem + 32'(is_mem[i]);
                    n_rd   = n_rd  + 32'(rd_need[i]);
                    n_tot  = n_tot + 32'd1;
                    stop   = is_br[i];
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

    assign any_live    = |live;
    assign out_mask    = sel;
    assign out_rd_need = sel & rd_need;
    assign out_last    = ((live & ~sel) == '0);
    assign out_valid   = in_valid & (|sel) & ~flush & ~rst;
    assign fire        = out_valid & out_ready;

    // Packets with nothing live are dropped straight away unless flushing or in reset
    assign in_ready = any_live ? (fire & out_last) : (in_valid & ~flush & ~rst);

    // Issued-slot tracking; flush beats a simultaneous fire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= '0;
        end else if (flush) begin
            done <= '0;
        end else if (fire && out_last) begin
            done <= '0;
        end else if (fire) begin
            done <= done | sel;
        end
    end

endmodule

// File: tb/tb_id_group_splitter.sv
// Directed table-driven bench for id_group_splitter (ID_WIDTH=4, MAX_BR=MAX_MEM=1).
module tb_id_group_splitter;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned AW = 5;

    localparam logic [19:0] RD_ALL = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [19:0] RD_X1  = {5'd4, 5'd3, 5'd0, 5'd1};
    localparam logic [19:0] RD_X0  = {5'd4, 5'd3, 5'd2, 5'd0};
    localparam logic [7:0]  T_ALU  = 8'h00;
    localparam logic [7:0]  T_BR0  = 8'h02;
    localparam logic [7:0]  T_MEM  = 8'h45;
    localparam logic [7:0]  T_BR02 = 8'h22;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [W-1:0]             in_slot_valid;
    logic [W-1:0][31:0]       in_inst;
    logic [W-1:0][1:0]        in_rs_type;
    logic [W-1:0][AW-1:0]     in_rd_arch;
    logic [CW-1:0]            fl_avail;
    logic [CW-1:0]            rob_avail;
    logic                     out_valid;
    logic                     out_ready;
    logic [W-1:0]             out_mask;
    logic [W-1:0]             out_rd_need;
    logic                     out_last;

    int n_cmp = 0;
    int n_err = 0;

    id_group_splitter #(.ID_WIDTH(W), .MAX_BR(1), .MAX_MEM(1), .ARF_IDX(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_slot_valid(in_slot_valid), .in_inst(in_inst),
        .in_rs_type(in_rs_type), .in_rd_arch(in_rd_arch),
        .fl_avail(fl_avail), .rob_avail(rob_avail),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mask(out_mask), .out_rd_need(out_rd_need), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [3:0]  vld;
        logic [3:0]  nz;
        logic [7:0]  rs;
        logic [19:0] rd;
        logic [2:0]  fl;
        logic [2:0]  rob;
        logic        iv;
        logic        ordy;
        logic        flsh;
        logic        ov;
        logic [3:0]  mask;
        logic [3:0]  need;
        logic        last;
        logic        ir;
        logic [3:0]  done;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(string tag, logic [3:0] vld, logic [3:0] nz, logic [7:0] rs,
                                logic [19:0] rd, logic [2:0] fl, logic [2:0] rob, logic iv,
                                logic ordy, logic flsh, logic ov, logic [3:0] mask,
                                logic [3:0] need, logic last, logic ir, logic [3:0] done);
        row_t r;
        r.tag = tag; r.vld = vld; r.nz = nz; r.rs = rs; r.rd = rd; r.fl = fl; r.rob = rob;
        r.iv = iv; r.ordy = ordy; r.flsh = flsh; r.ov = ov; r.mask = mask; r.need = need;
        r.last = last; r.ir = ir; r.done = done;
        return r;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(row_t r);
        in_valid      = r.iv;
        out_ready     = r.ordy;
        flush         = r.flsh;
        in_slot_valid = r.vld;
        in_rs_type    = r.rs;
        in_rd_arch    = r.rd;
        fl_avail      = r.fl;
        rob_avail     = r.rob;
        for (int i = 0; i < int'(W); i++)
            in_inst[i] = r.nz[i] ? (32'h0000_0013 | (32'(i) << 7)) : 32'h0;
    endtask

    task automatic run_row(row_t r);
        drive(r);
        @(negedge clk);
        check({r.tag, ".out_valid"},   32'(out_valid),   32'(r.ov));
        check({r.tag, ".out_mask"},    32'(out_mask),    32'(r.mask));
        check({r.tag, ".out_rd_need"}, 32'(out_rd_need), 32'(r.need));
        check({r.tag, ".out_last"},    32'(out_last),    32'(r.last));
        check({r.tag, ".in_ready"},    32'(in_ready),    32'(r.ir));
        @(posedge clk);
        #1;
        check({r.tag, ".done"}, 32'(dut.done), 32'(r.done));
    endtask

    initial begin
        //        tag        vld   nz    rs      rd      fl rob iv rdy fl  ov mask  need  last ir  done
        rows.push_back(mk("alu4",   4'hF, 4'hF, T_ALU,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'hF, 4'hF, 1, 1, 4'h0));
        rows.push_back(mk("br_c0",  4'hF, 4'hF, T_BR0,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'h1, 4'h1, 0, 0, 4'h1));
        rows.push_back(mk("br_c1",  4'hF, 4'hF, T_BR0,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'hE, 4'hE, 1, 1, 4'h0));
        rows.push_back(mk("mem_c0", 4'hF, 4'hF, T_MEM,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'h1, 4'h1, 0, 0, 4'h1));
        rows.push_back(mk("mem_c1", 4'hF, 4'hF, T_MEM,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'h6, 4'h6, 0, 0, 4'h7));
        rows.push_back(mk("mem_c2", 4'hF, 4'hF, T_MEM,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'h8, 4'h8, 1, 1, 4'h0));
        rows.push_back(mk("fl1_c0", 4'hF, 4'hF, T_ALU,  RD_X1,  1, 4, 1, 1, 0,  1, 4'h3, 4'h1, 0, 0, 4'h3));
        rows.push_back(mk("fl1_c1", 4'hF, 4'hF, T_ALU,  RD_X1,  1, 4, 1, 1, 0,  1, 4'h4, 4'h4, 0, 0, 4'h7));
        rows.push_back(mk("rob0_a", 4'hF, 4'hF, T_ALU,  RD_X1,  1, 0, 1, 1, 0,  0, 4'h0, 4'h0, 0, 0, 4'h7));
        rows.push_back(mk("rob0_b", 4'hF, 4'hF, T_ALU,  RD_X1,  1, 0, 1, 1, 0,  0, 4'h0, 4'h0, 0, 0, 4'h7));
        rows.push_back(mk("fl1_c2", 4'hF, 4'hF, T_ALU,  RD_X1,  1, 4, 1, 1, 0,  1, 4'h8, 4'h8, 1, 1, 4'h0));
        rows.push_back(mk("stl_c0", 4'hF, 4'hF, T_BR0,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'h1, 4'h1, 0, 0, 4'h1));
        rows.push_back(mk("stl_w0", 4'hF, 4'hF, T_BR0,  RD_ALL, 4, 4, 1, 0, 0,  1, 4'hE, 4'hE, 1, 0, 4'h1));
        rows.push_back(mk("stl_w1", 4'hF, 4'hF, T_BR0,  RD_ALL, 4, 4, 1, 0, 0,  1, 4'hE, 4'hE, 1, 0, 4'h1));
        rows.push_back(mk("stl_w2", 4'hF, 4'hF, T_BR0,  RD_ALL, 4, 4, 1, 0, 0,  1, 4'hE, 4'hE, 1, 0, 4'h1));
        rows.push_back(mk("stl_go", 4'hF, 4'hF, T_BR0,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'hE, 4'hE, 1, 1, 4'h0));
        rows.push_back(mk("fls_c0", 4'hF, 4'hF, T_BR0,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'h1, 4'h1, 0, 0, 4'h1));
        rows.push_back(mk("fls_hit",4'hF, 4'hF, T_BR0,  RD_ALL, 4, 4, 1, 1, 1,  0, 4'hE, 4'hE, 1, 0, 4'h0));
        rows.push_back(mk("fls_r0", 4'hF, 4'hF, T_BR0,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'h1, 4'h1, 0, 0, 4'h1));
        rows.push_back(mk("fls_r1", 4'hF, 4'hF, T_BR0,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'hE, 4'hE, 1, 1, 4'h0));
        rows.push_back(mk("fl0_a",  4'hF, 4'hF, T_ALU,  RD_ALL, 0, 4, 1, 1, 0,  0, 4'h0, 4'h0, 0, 0, 4'h0));
        rows.push_back(mk("fl0_b",  4'hF, 4'hF, T_ALU,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'hF, 4'hF, 1, 1, 4'h0));
        rows.push_back(mk("x0_a",   4'hF, 4'hF, T_ALU,  RD_X0,  0, 4, 1, 1, 0,  1, 4'h1, 4'h0, 0, 0, 4'h1));
        rows.push_back(mk("x0_b",   4'hF, 4'hF, T_ALU,  RD_X0,  4, 4, 1, 1, 0,  1, 4'hE, 4'hE, 1, 1, 4'h0));
        rows.push_back(mk("rob2_a", 4'hF, 4'hF, T_ALU,  RD_ALL, 4, 2, 1, 1, 0,  1, 4'h3, 4'h3, 0, 0, 4'h3));
        rows.push_back(mk("rob2_b", 4'hF, 4'hF, T_ALU,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'hC, 4'hC, 1, 1, 4'h0));
        rows.push_back(mk("part",   4'hA, 4'hF, T_ALU,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'hA, 4'hA, 1, 1, 4'h0));
        rows.push_back(mk("hole",   4'hF, 4'hB, T_ALU,  RD_ALL, 4, 4, 1, 1, 0,  1, 4'hB, 4'hB, 1, 1, 4'h0));
        rows.push_back(mk("nops",   4'hF, 4'h0, T_ALU,  RD_ALL, 4, 4, 1, 1, 0,  0, 4'h0, 4'h0, 1, 1, 4'h0));
        rows.push_back(mk("empty",  4'h0, 4'hF, T_ALU,  RD_ALL, 4, 4, 1, 1, 0,  0, 4'h0, 4'h0, 1, 1, 4'h0));
        rows.push_back(mk("empfls", 4'h0, 4'hF, T_ALU,  RD_ALL, 4, 4, 1, 1, 1,  0, 4'h0, 4'h0, 1, 0, 4'h0));
        rows.push_back(mk("noiv",   4'hF, 4'hF, T_ALU,  RD_ALL, 4, 4, 0, 1, 0,  0, 4'hF, 4'hF, 1, 0, 4'h0));
        rows.push_back(mk("bb_c0",  4'hF, 4'hF, T_BR02, RD_ALL, 4, 4, 1, 1, 0,  1, 4'h1, 4'h1, 0, 0, 4'h1));
        rows.push_back(mk("bb_c1",  4'hF, 4'hF, T_BR02, RD_ALL, 4, 4, 1, 1, 0,  1, 4'h6, 4'h6, 0, 0, 4'h7));
        rows.push_back(mk("bb_c2",  4'hF, 4'hF, T_BR02, RD_ALL, 4, 4, 1, 1, 0,  1, 4'h8, 4'h8, 1, 1, 4'h0));

        rst = 1'b1;
        drive(mk("idle", 4'h0, 4'h0, T_ALU, '0, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 4'h0));
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready",  32'(in_ready),  32'd0);
        check("reset.done",      32'(dut.done),  32'd0);
        rst = 1'b0;

        foreach (rows[k]) run_row(rows[k]);

        // Async reset in the middle of a split packet
        run_row(mk("arst_c0", 4'hF, 4'hF, T_BR0, RD_ALL, 4, 4, 1, 1, 0, 1, 4'h1, 4'h1, 0, 0, 4'h1));
        #2;
        rst = 1'b1;
        #1;
        check("arst.done",      32'(dut.done),  32'd0);
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.in_ready",  32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        check("arst.hold_done", 32'(dut.done),  32'd0);
        rst = 1'b0;
        run_row(mk("arst_inv", 4'h0, 4'h0, T_ALU, RD_ALL, 4, 4, 1, 1, 0, 0, 4'h0, 4'h0, 1, 1, 4'h0));
        run_row(mk("arst_new", 4'hF, 4'hF, T_BR0, RD_ALL, 4, 4, 1, 1, 0, 1, 4'h1, 4'h1, 0, 0, 4'h1));
        run_row(mk("arst_end", 4'hF, 4'hF, T_BR0, RD_ALL, 4, 4, 1, 1, 0, 1, 4'hE, 4'hE, 1, 1, 4'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_group_splitter.md
Name: id_group_splitter

Overview:
- N-wide decode-group splitter between the instruction queue and rename/dispatch.
- Each cycle it takes the packet at the queue head and issues the longest legal in-order prefix of its remaining slots.
- A prefix is legal within per-group branch/memory limits and within the free-list and ROB capacity reported this cycle.
- Issued slots are tracked in a done-mask register. The packet is popped only when its last live slot is issued; large or hazardous packets therefore drain over several cycles.

Parameters:
- ID_WIDTH, 4, slots per fetch packet (1..8).
- MAX_BR, 1, max RS_BR uops per issued group (>=1).
- MAX_MEM, 1, max RS_MEM uops per issued group (>=1).
- CNT_W, $clog2(ID_WIDTH+1), width of capacity counts.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  backend flush; discard partial-packet progress
- in_valid  in  1  queue head packet valid
- in_ready  out  1  pop queue head this cycle
- in_slot_valid  in  ID_WIDTH  per-slot valid
- in_inst  in  ID_WIDTH x 32  raw instructions
- in_rs_type  in  ID_WIDTH x 2  decoded RS type (uop_types RS_* encoding)
- in_rd_arch  in  ID_WIDTH x ARF_IDX  decoded destination
- fl_avail  in  CNT_W  free physical registers poppable this cycle
- rob_avail  in  CNT_W  free ROB entries this cycle
- out_valid  out  1  group offered to rename/dispatch
- out_ready  in  1  rename/dispatch accepts group
- out_mask  out  ID_WIDTH  slots issued in this group
- out_rd_need  out  ID_WIDTH  issued slots needing a physical rd (rd_arch != 0)
- out_last  out  1  this group completes the packet

Behaviour:
- State: done[ID_WIDTH]. Reset value 0 (async on rst).
- live[i] = in_slot_valid[i] & (in_inst[i] != 0) & ~done[i]. All-zero instructions are treated as dead slots.
- Selection is combinational. Scan i = 0..ID_WIDTH-1, skipping non-live slots.
- Slot i is taken only if all of the following hold, counting taken slots plus i:
  - RS_BR count <= MAX_BR;
  - RS_MEM count <= MAX_MEM;
  - rd_need count <= fl_avail;
  - total count <= rob_avail.
- The first live slot that fails any check stops the scan. Slots are never skipped, so groups stay program-ordered.
- A taken RS_BR slot also stops the scan: a branch is always the last slot in its group.
- sel = taken slots.
- out_mask = sel; out_rd_need = sel & (rd_arch != 0).
- out_last = ((done | sel) covers every live-or-done slot), i.e. no live slot remains outside sel.
- out_valid = in_valid & (sel != 0) & ~flush.
- fire = out_valid & out_ready.
- Packet with no live slots (all invalid or nop): out_valid = 0, in_ready = in_valid & ~flush, done unchanged (0).
- Otherwise in_ready = fire & out_last.
- done update at clk edge, in priority order:
  1. rst -> 0.
  2. flush -> 0.
  3. fire & out_last -> 0.
  4. fire -> done | sel.
  5. Otherwise hold.
- Zero capacity (fl_avail = 0 with a live rd slot first, or rob_avail = 0): sel = 0, out_valid = 0, done holds. No deadlock once capacity returns.
- sel is recomputed every cycle from current inputs. It is not guaranteed stable while out_ready is low; downstream consumes only on fire.
- Simultaneous flush and fire: flush wins. No pop, done cleared.
- Reset mid-packet: done clears immediately. While rst is high, out_valid and in_ready are 0. The next packet starts at slot 0.
- No output registers. Latency from in_* to out_* is 0 cycles; the only state is done.
- ID_WIDTH = 1 degenerates to pass-through gated by the capacity checks.

Test Plan:
1. ID_WIDTH=4, four ALU ops, rd=x1..x4, fl_avail=rob_avail=4, out_ready=1 -> one cycle: out_mask=1111, out_last=1, in_ready=1, done stays 0.
2. Slots BR,ALU,ALU,ALU -> cycle0 out_mask=0001, out_last=0, in_ready=0, done=0001; cycle1 out_mask=1110, out_last=1, in_ready=1, done=0.
3. Slots MEM,MEM,ALU,MEM, MAX_MEM=1 -> groups 0001, 0110, 1000; in_ready high only in third cycle.
4. Four ALU ops, fl_avail=1; slot1 rd=x0 -> groups 0011, 0100, 1000 (x0 slot consumes no free reg; out_rd_need=0001 in first group). Then rob_avail=0 for two cycles -> out_valid=0, done held.
5. After group 0001 is issued, hold out_ready=0 for 3 cycles -> done=0001 held, in_ready=0, out_mask=1110 offered each cycle. Then out_ready=1 -> pop.
6. Flush asserted after the first group of a split packet, with out_ready=1 the same cycle -> no pop, done=0. Separately, async rst pulse mid-packet -> done=0 immediately, out_valid=0 during reset; next packet with all slots invalid -> immediate in_ready=1, out_valid=0.
